// File: rtl/seq_decoder.sv
// One-hot index decoder with direct decode, prescaled up/down scanning and hold.
// Outputs d, idx and wrap come straight from flops; d is precomputed from next-state.
module seq_decoder #(
   parameter int SEL_W    = 4,
   parameter int SCAN_DIV = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  e,
   input  logic [SEL_W-1:0]      sel,
   input  logic [1:0]            mode,
   input  logic                  load,
   output logic [2**SEL_W-1:0]   d,
   output logic [SEL_W-1:0]      idx,
   output logic                  wrap
);

   localparam int OUT_W = 2**SEL_W;
   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [SEL_W-1:0] IDX_ZERO = {SEL_W{1'b0}};
   localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);
   localparam logic [SEL_W-1:0] IDX_LAST = {SEL_W{1'b1}};
   localparam logic [OUT_W-1:0] D_ZERO   = {OUT_W{1'b0}};
   localparam logic [OUT_W-1:0] D_ONE    = OUT_W'(1);

   typedef enum logic [1:0] {
      MODE_DECODE = 2'b00,
      MODE_UP     = 2'b01,
      MODE_DOWN   = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_t;

   function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
      return D_ONE << i;
   endfunction

   mode_t             mode_s;
   mode_t             mode_q_r;
   logic [SEL_W-1:0]  idx_r,  idx_s;
   logic [PRE_W-1:0]  pre_r,  pre_s;
   logic              act_r,  act_s;
   logic              wrap_r, wrap_s;
   logic [OUT_W-1:0]  d_r,    d_s;

   assign mode_s = mode_t'(mode);

   // Next-state: load beats everything, a mode change only realigns the prescaler.
   always_comb begin
      idx_s  = idx_r;
      act_s  = act_r;
      pre_s  = pre_r;
      wrap_s = 1'b0;
      if (load) begin
         idx_s = sel;
         act_s = e;
         pre_s = PRE_ZERO;
      end else if (mode_s != mode_q_r) begin
         pre_s = PRE_ZERO;
         act_s = e;
         if (mode_s == MODE_DECODE) begin
            idx_s = sel;
         end else begin
            idx_s = idx_r;
         end
      end else begin
         case (mode_s)
            MODE_DECODE: begin
               idx_s = sel;
               act_s = e;
               pre_s = PRE_ZERO;
            end
            MODE_UP, MODE_DOWN: begin
               act_s = e;
               if (!e) begin
                  pre_s = pre_r;
               end else if (pre_r != PRE_LAST) begin
                  pre_s = pre_r + PRE_ONE;
               end else if (mode_s == MODE_UP) begin
                  pre_s  = PRE_ZERO;
                  idx_s  = idx_r + IDX_ONE;
                  wrap_s = (idx_r == IDX_LAST);
               end else begin
                  pre_s  = PRE_ZERO;
                  idx_s  = idx_r - IDX_ONE;
                  wrap_s = (idx_r == IDX_ZERO);
               end
            end
            MODE_HOLD: begin
               act_s = e;
            end
            default: begin
               act_s = 1'b0;
            end
         endcase
      end
      if (act_s) begin
         d_s = onehot(idx_s);
      end else begin
         d_s = D_ZERO;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r    <= IDX_ZERO;
         act_r    <= 1'b0;
         pre_r    <= PRE_ZERO;
         wrap_r   <= 1'b0;
         mode_q_r <= MODE_DECODE;
         d_r      <= D_ZERO;
      end else begin
         idx_r    <= idx_s;
         act_r    <= act_s;
         pre_r    <= pre_s;
         wrap_r   <= wrap_s;
         mode_q_r <= mode_s;
         d_r      <= d_s;
      end
   end

   assign d    = d_r;
   assign idx  = idx_r;
   assign wrap = wrap_r;

endmodule

// File: tb/tb_seq_decoder.sv
// Randomised and directed checks of seq_decoder (SCAN_DIV 1 and 3) against a behavioural model.
module tb_seq_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        e;
   logic [3:0]  sel;
   logic [1:0]  mode;
   logic        load;
   logic [15:0] d0, d3;
   logic [3:0]  idx0, idx3;
   logic        wrap0, wrap3;

   int n_tests = 0;
   int n_fail  = 0;

   int m_idx[2], m_act[2], m_pre[2], m_mq[2], m_wrap[2];
   int m_div[2] = '{1, 3};

   always #5 clk = ~clk;

   seq_decoder dut1 (
      .clk(clk), .rst_n(rst_n), .e(e), .sel(sel), .mode(mode), .load(load),
      .d(d0), .idx(idx0), .wrap(wrap0)
   );

   seq_decoder #(.SEL_W(4), .SCAN_DIV(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .e(e), .sel(sel), .mode(mode), .load(load),
      .d(d3), .idx(idx3), .wrap(wrap3)
   );

   task automatic model_reset(input int k);
      m_idx[k] = 0; m_act[k] = 0; m_pre[k] = 0; m_mq[k] = 0; m_wrap[k] = 0;
   endtask

   // Cycle behaviour written from the rules: load, then mode change, then the mode itself.
   task automatic model_step(input int k);
      int md;
      md = int'(mode);
      m_wrap[k] = 0;
      if (load) begin
         m_idx[k] = int'(sel); m_act[k] = int'(e); m_pre[k] = 0;
      end else if (md != m_mq[k]) begin
         m_pre[k] = 0; m_act[k] = int'(e);
         if (md == 0) m_idx[k] = int'(sel);
      end else if (md == 0) begin
         m_idx[k] = int'(sel); m_act[k] = int'(e); m_pre[k] = 0;
      end else if (md == 3 || !e) begin
         m_act[k] = int'(e);
      end else begin
         m_act[k] = 1;
         if (m_pre[k] == m_div[k] - 1) begin
            m_pre[k] = 0;
            if (md == 1) begin
               if (m_idx[k] == 15) m_wrap[k] = 1;
               m_idx[k] = (m_idx[k] + 1) % 16;
            end else begin
               if (m_idx[k] == 0) m_wrap[k] = 1;
               m_idx[k] = (m_idx[k] + 15) % 16;
            end
         end else begin
            m_pre[k] = m_pre[k] + 1;
         end
      end
      m_mq[k] = md;
   endtask

   function automatic logic [20:0] exp_vec(input int k);
      logic [15:0] dv;
      dv = (m_act[k] != 0) ? (16'h0001 << m_idx[k]) : 16'h0000;
      return {dv, 4'(m_idx[k]), (m_wrap[k] != 0)};
   endfunction

   task automatic cyc();
      @(posedge clk);
      if (rst_n) begin
         model_step(0); model_step(1);
      end else begin
         model_reset(0); model_reset(1);
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         e = 1'b1; sel = 4'($urandom); mode = 2'($urandom); load = 1'($urandom);
         cyc();
         n_tests++;
         if ({d0, idx0, wrap0, d3, idx3, wrap3} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h/%h/%b %h/%h/%b, required all zero", d0, idx0, wrap0, d3, idx3, wrap3);
         end
      end
      e = 1'b0; sel = 4'd0; mode = 2'b00; load = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_decode_sweep();
      mode = 2'b00; load = 1'b0; e = 1'b1;
      for (int s = 0; s < 16; s++) begin
         sel = 4'(s);
         cyc();
         n_tests++;
         if (d0 !== (16'h0001 << s) || {d3, idx3, wrap3} !== exp_vec(1)) begin
            n_fail++;
            $display("FAIL decode_sweep sel=%0d: got d=%h d3=%h, required %h", s, d0, d3, 16'h0001 << s);
         end
      end
      e = 1'b0;
      cyc();
      n_tests++;
      if (d0 !== 16'h0000 || d3 !== 16'h0000) begin
         n_fail++;
         $display("FAIL decode_disabled: got %h %h, required 0000", d0, d3);
      end
   endtask

   task automatic test_scan_wrap();
      int exp_idx[4] = '{14, 15, 0, 1};
      load = 1'b1; sel = 4'd14; mode = 2'b00; e = 1'b1;
      cyc();
      load = 1'b0; mode = 2'b01;
      for (int i = 0; i < 4; i++) begin
         cyc();
         n_tests++;
         if (idx0 !== 4'(exp_idx[i]) || wrap0 !== (i == 2) || d0 !== (16'h0001 << exp_idx[i])
             || {d3, idx3, wrap3} !== exp_vec(1)) begin
            n_fail++;
            $display("FAIL scan_wrap step %0d: got idx=%0d wrap=%b d=%h, required idx=%0d wrap=%b",
                     i, idx0, wrap0, d0, exp_idx[i], i == 2);
         end
      end
   endtask

   task automatic test_scan_div3();
      int wraps = 0;
      load = 1'b1; sel = 4'd0; mode = 2'b00; e = 1'b1;
      cyc();
      load = 1'b0; mode = 2'b10;
      for (int c = 1; c <= 12; c++) begin
         cyc();
         if (wrap3) wraps++;
         n_tests++;
         if (idx3 !== 4'((16 - (c - 1) / 3) % 16) || {d3, idx3, wrap3} !== exp_vec(1)
             || {d0, idx0, wrap0} !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL scan_div3 cycle %0d: got idx3=%0d, required %0d", c, idx3, (16 - (c - 1) / 3) % 16);
         end
      end
      n_tests++;
      if (wraps != 1) begin
         n_fail++;
         $display("FAIL scan_div3_wrap_count: got %0d, required 1", wraps);
      end
   endtask

   task automatic test_enable_gap();
      logic [3:0] f0, f3;
      mode = 2'b01; e = 1'b1; load = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      f0 = idx0; f3 = idx3;
      e = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         n_tests++;
         if (d0 !== 16'h0000 || d3 !== 16'h0000 || idx0 !== f0 || idx3 !== f3 || wrap0 !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_gap_frozen: got d=%h idx=%0d idx3=%0d, required d=0 idx=%0d idx3=%0d",
                     d0, idx0, idx3, f0, f3);
         end
      end
      e = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         n_tests++;
         if ((i == 0 && idx0 !== f0 + 4'd1) || {d0, idx0, wrap0} !== exp_vec(0) || {d3, idx3, wrap3} !== exp_vec(1)) begin
            n_fail++;
            $display("FAIL enable_gap_resume %0d: got idx=%0d idx3=%0d, required %0d %0d",
                     i, idx0, idx3, m_idx[0], m_idx[1]);
         end
      end
   endtask

   task automatic test_async_reset();
      int n = 0;
      mode = 2'b01; e = 1'b1; load = 1'b0;
      do begin
         cyc(); n++;
      end while (m_idx[0] != 9 && n < 40);
      n_tests++;
      if (idx0 !== 4'd9) begin
         n_fail++;
         $display("FAIL async_reset_reach9: got idx=%0d after %0d cycles, required 9", idx0, n);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({d0, idx0, wrap0, d3, idx3, wrap3} !== 42'd0) begin
         n_fail++;
         $display("FAIL async_reset_immediate: got d=%h idx=%0d, required 0 0", d0, idx0);
      end
      model_reset(0); model_reset(1);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         n_tests++;
         if (idx0 !== 4'(i) || {d0, idx0, wrap0} !== exp_vec(0) || {d3, idx3, wrap3} !== exp_vec(1)) begin
            n_fail++;
            $display("FAIL async_reset_restart %0d: got idx=%0d, required %0d", i, idx0, i);
         end
      end
   endtask

   task automatic test_load_priority();
      int n = 0;
      mode = 2'b01; e = 1'b1; load = 1'b0;
      do begin
         cyc(); n++;
      end while (m_idx[0] != 15 && n < 40);
      load = 1'b1; sel = 4'd5;
      cyc();
      load = 1'b0;
      n_tests++;
      if (idx0 !== 4'd5 || wrap0 !== 1'b0 || d0 !== 16'h0020 || {d3, idx3, wrap3} !== exp_vec(1)) begin
         n_fail++;
         $display("FAIL load_priority: got idx=%0d wrap=%b d=%h, required 5 0 0020", idx0, wrap0, d0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         load = ($urandom_range(0, 9) == 0);
         sel  = 4'($urandom);
         e    = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 5) == 0) mode = 2'($urandom);
         cyc();
         n_tests++;
         if ({d0, idx0, wrap0} !== exp_vec(0) || {d3, idx3, wrap3} !== exp_vec(1)) begin
            n_fail++;
            $display("FAIL random cycle %0d: got %h/%h, required %h/%h",
                     i, {d0, idx0, wrap0}, {d3, idx3, wrap3}, exp_vec(0), exp_vec(1));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; e = 1'b0; sel = 4'd0; mode = 2'b00; load = 1'b0;
      model_reset(0); model_reset(1);
      #2;
      test_reset();
      test_decode_sweep();
      test_scan_wrap();
      test_scan_div3();
      test_enable_gap();
      test_async_reset();
      test_load_priority();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seq_decoder.md
SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001: Parameter SEL_W, default 4, is the select width; legal range 1..8.
REQ-002: Parameter SCAN_DIV, default 1, is the clock cycles per scan step; legal range 1..256.
REQ-003: Derived constant OUT_W = 2**SEL_W is the output width; it SHALL NOT be overridable.
REQ-004: Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-005: Port rst_n, input, 1 bit, is the asynchronous active-low reset.
REQ-006: Port e, input, 1 bit, is the enable; when low, the decoded output SHALL be all-zero.
REQ-007: Port sel, input, SEL_W bits, is the direct select index.
REQ-008: Port mode, input, 2 bits: 00 = decode, 01 = scan up, 10 = scan down, 11 = hold.
REQ-009: Port load, input, 1 bit, is a strobe that forces idx to sel in any mode.
REQ-010: Port d, output, OUT_W bits, is the one-hot decoded output, driven directly from flops.
REQ-011: Port idx, output, SEL_W bits, is the current index register.
REQ-012: Port wrap, output, 1 bit, is a one-cycle pulse on scan wrap-around.

Function
REQ-013: Internal state SHALL be idx (SEL_W bits), act (1 bit), pre (prescaler, ceil(log2(SCAN_DIV)) bits, minimum 1), and mode_q (last-cycle mode).
REQ-014: d SHALL equal (1 << idx) when act = 1 and all-zero when act = 0; d SHALL never have more than one bit set.
REQ-015: Priority per cycle SHALL be: load > mode.
REQ-016: Load: when load = 1, then idx <= sel, act <= e, pre <= 0, and wrap <= 0, regardless of mode.
REQ-017: Decode (mode 00, load = 0): idx <= sel, act <= e, pre <= 0; d reflects sel/e with exactly one cycle of latency.
REQ-018: Scan up (mode 01, load = 0, e = 1): pre increments each cycle; when pre = SCAN_DIV-1, then pre <= 0 and idx <= idx+1 modulo OUT_W.
REQ-019: Scan down (mode 10, load = 0, e = 1): same as scan up, except idx <= idx-1 modulo OUT_W.
REQ-020: Wrap: wrap <= 1 for exactly the cycle following a step from OUT_W-1 to 0 (scan up) or from 0 to OUT_W-1 (scan down); otherwise wrap <= 0.
REQ-021: Scan with e = 0: idx and pre hold, act <= 0, wrap <= 0; scanning resumes from the held idx and pre when e returns high.
REQ-022: Hold (mode 11, load = 0): idx and pre hold, act <= e, wrap <= 0.
REQ-023: A mode change (mode != mode_q) with load = 0 SHALL clear pre to 0 in that cycle, and idx SHALL NOT step in that cycle.
REQ-024: With SCAN_DIV = 1, idx SHALL step every enabled scan cycle, and pre SHALL remain 0.
REQ-025: Simultaneous load = 1 and a scan step condition: load wins; no step and no wrap occur.
REQ-026: With SEL_W = 1, scan SHALL toggle idx between 0 and 1, and wrap SHALL pulse on every 1->0 step (up) or 0->1 step (down).

Reset
REQ-027: While rst_n = 0, idx, act, pre, and wrap SHALL be 0 and mode_q SHALL be 00, immediately and without a clock; hence d = 0 and idx = 0.
REQ-028: Reset asserted mid-scan SHALL abort the scan; after release, operation SHALL restart from idx = 0 with pre = 0.
REQ-029: Reset deassertion SHALL be synchronous to clk at the integration level; the block SHALL take its first update on the first rising edge with rst_n = 1.

Verification
REQ-030: Defaults; mode 00, e = 1, sweep sel 0..15 -> one cycle later d = 16'h0001 << sel each time; with e = 0, d = 16'h0000.
REQ-031: Defaults; load with sel = 14, then mode 01, e = 1 for 4 cycles -> idx sequence 14, 15, 0, 1; wrap is high only in the cycle when idx = 0; d = 16'h4000, 16'h8000, 16'h0001, 16'h0002.
REQ-032: SCAN_DIV = 3; load with sel = 0, then mode 10 -> idx holds 3 cycles per step with sequence 0, 15, 14; wrap pulses once on entry to 15.
REQ-033: Mid-scan, drop e for 5 cycles -> d = 0 and idx frozen; restore e -> stepping continues from the frozen idx, with no extra step or lost step.
REQ-034: Assert rst_n low asynchronously, between edges, during scan at idx = 9 -> d = 0 and idx = 0 immediately; after release in mode 01, the first step goes to idx = 1.
REQ-035: load = 1 with sel = 5 on the same edge that scan up would step 15 -> 0 -> idx = 5 and wrap = 0.
